// File: rtl/i_cache_fill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : i_cache_fill_ctrl
//  Description : Instruction-cache miss/refill engine. Takes the registered
//                miss request from the cache. Fetches the 4-word line that
//                holds the miss address, one word at a time. Assembles the
//                line and returns it with its tag and a round-robin victim
//                way.
//  Ports       :
//     clk              - single clock, all state on rising edge
//     rst              - asynchronous active-low reset
//     miss_valid       - cache miss request valid (level, may persist)
//     miss_address     - missing PC, [3:0] ignored
//     invalidate       - forget the last filled line
//     mem_req_valid    - word read request valid
//     mem_req_ready    - memory accepts the request this cycle
//     mem_req_address  - word address {tag, word_idx, 2'b00}
//     mem_rsp_valid    - read data valid
//     mem_rsp_data     - read data word
//     fill_rsp_valid   - one-cycle pulse, line ready for the cache write
//     fill_rsp_tag     - tag of the filled line
//     fill_rsp_data    - filled line, word k at [32k+31:32k]
//     fill_rsp_way     - victim way to overwrite
//     busy             - high in every state except IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module i_cache_fill_ctrl #(
   parameter  int WAYS_NUM          = 16,
   parameter  int CL_WIDTH          = 128,
   parameter  int TAG_ADDRESS_WIDTH = 28,
   localparam int WAY_W             = (WAYS_NUM > 1) ? $clog2(WAYS_NUM) : 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         miss_valid,
   input  logic [31:0]                  miss_address,
   input  logic                         invalidate,
   output logic                         mem_req_valid,
   input  logic                         mem_req_ready,
   output logic [31:0]                  mem_req_address,
   input  logic                         mem_rsp_valid,
   input  logic [31:0]                  mem_rsp_data,
   output logic                         fill_rsp_valid,
   output logic [TAG_ADDRESS_WIDTH-1:0] fill_rsp_tag,
   output logic [CL_WIDTH-1:0]          fill_rsp_data,
   output logic [WAY_W-1:0]             fill_rsp_way,
   output logic                         busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RSP  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                         r_state;
   state_t                         w_next;

   logic [TAG_ADDRESS_WIDTH-1:0]   r_tag;
   logic [1:0]                     r_word_idx;
   logic [CL_WIDTH-1:0]            r_line;
   logic [WAY_W-1:0]               r_victim;
   logic                           r_last_valid;
   logic [TAG_ADDRESS_WIDTH-1:0]   r_last_tag;
   logic [TAG_ADDRESS_WIDTH-1:0]   r_out_tag;
   logic [CL_WIDTH-1:0]            r_out_data;
   logic [WAY_W-1:0]               r_out_way;

   logic                           w_suppress;
   logic                           w_start;
   logic                           w_rsp_beat;
   logic                           w_last_beat;
   logic [CL_WIDTH-1:0]            w_line_wr;
   logic                           w_unused;

   // The cache keeps presenting its registered miss for a cycle or more after
   // the fill lands; matching it against the line just filled stops a
   // redundant refetch of the same line.
   assign w_suppress  = r_last_valid && (miss_address[31:4] == r_last_tag);
   assign w_start     = (r_state == S_IDLE) && miss_valid && !w_suppress;
   assign w_rsp_beat  = (r_state == S_RSP) && mem_rsp_valid;
   assign w_last_beat = w_rsp_beat && (r_word_idx == 2'd3);

   // Byte offset inside the line is irrelevant to a line fill.
   assign w_unused    = ^miss_address[3:0];

   // ------------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // ------------------------------------------------------------------------
   // FSM next state and state-decoded outputs
   // ------------------------------------------------------------------------
   always_comb begin
      w_next          = r_state;
      mem_req_valid   = 1'b0;
      mem_req_address = 32'd0;
      fill_rsp_valid  = 1'b0;
      busy            = 1'b1;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (w_start) begin
               w_next = S_REQ;
            end
         end
         S_REQ: begin
            mem_req_valid   = 1'b1;
            mem_req_address = {r_tag, r_word_idx, 2'b00};
            if (mem_req_ready) begin
               w_next = S_RSP;
            end
         end
         S_RSP: begin
            if (mem_rsp_valid) begin
               w_next = (r_word_idx == 2'd3) ? S_DONE : S_REQ;
            end
         end
         S_DONE: begin
            fill_rsp_valid = 1'b1;
            w_next         = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Line buffer with the incoming word merged in at the current index.
   always_comb begin
      w_line_wr = r_line;
      w_line_wr[{r_word_idx, 5'd0} +: 32] = mem_rsp_data;
   end

   // ------------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tag        <= '0;
         r_word_idx   <= 2'd0;
         r_line       <= '0;
         r_victim     <= '0;
         r_last_valid <= 1'b0;
         r_last_tag   <= '0;
         r_out_tag    <= '0;
         r_out_data   <= '0;
         r_out_way    <= '0;
      end else begin
         if (w_start) begin
            r_tag      <= miss_address[31:4];
            r_word_idx <= 2'd0;
         end

         if (w_rsp_beat) begin
            r_line <= w_line_wr;
            if (r_word_idx != 2'd3) begin
               r_word_idx <= r_word_idx + 2'd1;
            end
         end

         // Result registers load one cycle ahead of the pulse and then hold
         // until the next completed fill, so the cache may sample late.
         if (w_last_beat) begin
            r_out_data <= w_line_wr;
            r_out_tag  <= r_tag;
            r_out_way  <= r_victim;
         end

         // DONE takes priority over a coincident invalidate.
         if (r_state == S_DONE) begin
            r_last_valid <= 1'b1;
            r_last_tag   <= r_tag;
            if (r_victim == WAY_W'(WAYS_NUM - 1)) begin
               r_victim <= '0;
            end else begin
               r_victim <= r_victim + 1'b1;
            end
         end else if (invalidate) begin
            r_last_valid <= 1'b0;
         end
      end
   end

   assign fill_rsp_tag  = r_out_tag;
   assign fill_rsp_data = r_out_data;
   assign fill_rsp_way  = r_out_way;

endmodule
`default_nettype wire

// File: tb/tb_i_cache_fill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i_cache_fill_ctrl
//  Description : Self-checking bench for i_cache_fill_ctrl. Stimulus pushes
//                expected word requests and expected fills into queues. A
//                memory responder and a fill monitor pop and compare them.
//                Expected values come from a line-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i_cache_fill_ctrl;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         miss_valid;
   logic [31:0]  miss_address;
   logic         invalidate;
   logic         mem_req_valid;
   logic         mem_req_ready;
   logic [31:0]  mem_req_address;
   logic         mem_rsp_valid;
   logic [31:0]  mem_rsp_data;
   logic         fill_rsp_valid;
   logic [27:0]  fill_rsp_tag;
   logic [127:0] fill_rsp_data;
   logic [3:0]   fill_rsp_way;
   logic         busy;

   i_cache_fill_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .miss_valid      (miss_valid),
      .miss_address    (miss_address),
      .invalidate      (invalidate),
      .mem_req_valid   (mem_req_valid),
      .mem_req_ready   (mem_req_ready),
      .mem_req_address (mem_req_address),
      .mem_rsp_valid   (mem_rsp_valid),
      .mem_rsp_data    (mem_rsp_data),
      .fill_rsp_valid  (fill_rsp_valid),
      .fill_rsp_tag    (fill_rsp_tag),
      .fill_rsp_data   (fill_rsp_data),
      .fill_rsp_way    (fill_rsp_way),
      .busy            (busy)
   );

   always #5 clk = ~clk;

   // Number of rising edges so far; at a falling edge this is the index of
   // the current cycle.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   function automatic void chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   function automatic void fail(input string nm);
      n_tests++;
      n_fail++;
      $display("FAIL %s (cycle %0d)", nm, cyc);
   endfunction

   // ---------------- reference model ----------------
   typedef struct {
      logic [27:0]  tag;
      logic [127:0] data;
      logic [3:0]   way;
      int           when;   // expected pulse cycle, -1 = not timed
   } fill_t;

   fill_t       exp_fills[$];
   logic [31:0] exp_addrs[$];
   int          m_way        = 0;
   bit          m_last_valid = 0;
   logic [27:0] m_last_tag   = '0;

   // Memory contents: line tag 0x0000123 reads back 0xA0+k.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] base;
      base = 32'(a[31:4] - 28'h0000123);
      return 32'hA0 + 32'(a[3:2]) + (base << 8);
   endfunction

   // Called at a falling edge with the DUT idle; presents the miss and
   // records everything the DUT should produce for it.
   task automatic start_miss(input logic [31:0] addr, input bit timed, input int extra,
                             output bit acc, output int t0);
      fill_t       f;
      logic [27:0] tag;
      tag = addr[31:4];
      chk("start_idle", {159'd0, busy}, 160'd0);
      miss_valid   = 1'b1;
      miss_address = addr;
      t0  = cyc;
      acc = !(m_last_valid && (tag == m_last_tag));
      if (acc) begin
         f.tag = tag;
         for (int k = 0; k < 4; k++) begin
            exp_addrs.push_back({tag, 2'(k), 2'b00});
            f.data[32*k +: 32] = mem_word({tag, 2'(k), 2'b00});
         end
         f.way  = 4'(m_way);
         f.when = timed ? (t0 + 9 + extra) : -1;
         exp_fills.push_back(f);
         m_way        = (m_way + 1) % 16;
         m_last_valid = 1'b1;
         m_last_tag   = tag;
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < 400);
      if (busy) fail("idle_timeout");
   endtask

   task automatic chk_zero_outputs(input string nm);
      chk({nm, "_req_valid"},  {159'd0, mem_req_valid},   160'd0);
      chk({nm, "_req_addr"},   {128'd0, mem_req_address}, 160'd0);
      chk({nm, "_fill_valid"}, {159'd0, fill_rsp_valid},  160'd0);
      chk({nm, "_fill_tag"},   {132'd0, fill_rsp_tag},    160'd0);
      chk({nm, "_fill_data"},  {32'd0, fill_rsp_data},    160'd0);
      chk({nm, "_fill_way"},   {156'd0, fill_rsp_way},    160'd0);
      chk({nm, "_busy"},       {159'd0, busy},            160'd0);
   endtask

   // ---------------- memory responder ----------------
   bit          rdy_random = 0;
   int          lat_max    = 1;
   int          stall_left = 0;
   bit          stray_en   = 0;

   initial begin : responder
      bit          pend     = 0;
      int          pend_cnt = 0;
      logic [31:0] pend_addr;
      bit          acc_prev  = 0;
      logic [31:0] acc_addr;
      bit          hold_prev = 0;
      logic [31:0] hold_addr;
      bit          rdy;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            pend = 0; acc_prev = 0; hold_prev = 0;
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b0;
         end else begin
            if (hold_prev) begin
               chk("req_hold_valid", {159'd0, mem_req_valid}, 160'd1);
               chk("req_hold_addr", {128'd0, mem_req_address}, {128'd0, hold_addr});
            end
            if (acc_prev) begin
               pend      = 1;
               pend_addr = acc_addr;
               pend_cnt  = int'($urandom_range(lat_max - 1, 0));
            end
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = $urandom;
            if (pend) begin
               if (pend_cnt == 0) begin
                  mem_rsp_valid = 1'b1;
                  mem_rsp_data  = mem_word(pend_addr);
                  pend = 0;
               end else begin
                  pend_cnt--;
               end
            end else if (stray_en && $urandom_range(3, 0) == 0) begin
               mem_rsp_valid = 1'b1;   // junk beat outside a response window
            end
            if (mem_req_valid && mem_req_address[3:2] == 2'd1 && stall_left > 0) begin
               rdy = 1'b0;
               stall_left--;
            end else begin
               rdy = rdy_random ? ($urandom_range(9, 0) < 7) : 1'b1;
            end
            mem_req_ready = rdy;
            acc_prev  = mem_req_valid && rdy;
            acc_addr  = mem_req_address;
            hold_prev = mem_req_valid && !rdy;
            hold_addr = mem_req_address;
            if (acc_prev) begin
               if (exp_addrs.size() == 0) fail("unexpected_req");
               else chk("req_addr", {128'd0, mem_req_address}, {128'd0, exp_addrs.pop_front()});
            end
         end
      end
   end

   // ---------------- fill monitor ----------------
   initial begin : monitor
      fill_t e;
      fill_t last;
      bit    have_last = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            have_last = 0;
         end else if (fill_rsp_valid) begin
            if (exp_fills.size() == 0) begin
               fail("unexpected_fill");
            end else begin
               e = exp_fills.pop_front();
               chk("fill_tag",  {132'd0, fill_rsp_tag},  {132'd0, e.tag});
               chk("fill_data", {32'd0, fill_rsp_data},  {32'd0, e.data});
               chk("fill_way",  {156'd0, fill_rsp_way},  {156'd0, e.way});
               if (e.when >= 0) chk("fill_cycle", 160'(cyc), 160'(e.when));
               last      = e;
               have_last = 1;
            end
         end else if (have_last) begin
            chk("fill_hold", {fill_rsp_tag, fill_rsp_way, fill_rsp_data},
                             {last.tag, last.way, last.data});
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin : stim
      bit          acc;
      int          t0;
      int          n;
      logic [31:0] addr;
      miss_valid   = 1'b0;
      miss_address = '0;
      invalidate   = 1'b0;
      repeat (3) @(negedge clk);
      chk_zero_outputs("reset");
      rst = 1'b1;

      // Basic fill; miss held as the cache would, then suppressed.
      wait_idle();
      start_miss(32'h0000_1238, 1, 0, acc, t0);
      wait_idle();
      repeat (5) begin
         @(negedge clk);
         chk("suppress_busy", {159'd0, busy}, 160'd0);
      end
      // Invalidate releases the held miss into a refill of the same line.
      invalidate   = 1'b1;
      m_last_valid = 1'b0;
      @(negedge clk);
      invalidate = 1'b0;
      start_miss(32'h0000_1238, 1, 0, acc, t0);
      wait_idle();
      miss_valid = 1'b0;

      // Three-cycle ready stall on word 1.
      @(negedge clk);
      stall_left = 3;
      start_miss(32'h0000_5670, 1, 3, acc, t0);
      wait_idle();
      miss_valid = 1'b0;
      chk("stall_used", 160'(stall_left), 160'd0);

      // Stray beats, a second miss and invalidates during the fill.
      @(negedge clk);
      stray_en = 1;
      start_miss(32'h0000_9AB4, 1, 0, acc, t0);
      repeat (3) @(negedge clk);
      miss_address = 32'h000F_0000;
      @(negedge clk);
      miss_address = 32'h0000_9AB4;
      invalidate   = 1'b1;
      @(negedge clk);
      invalidate = 1'b0;
      n = 0;
      while (cyc < t0 + 9 && n < 50) begin
         @(negedge clk);
         n++;
      end
      invalidate = 1'b1;   // coincides with the fill pulse
      @(negedge clk);
      invalidate = 1'b0;
      wait_idle();
      repeat (4) begin
         @(negedge clk);
         chk("done_wins_busy", {159'd0, busy}, 160'd0);
      end
      miss_valid = 1'b0;
      stray_en   = 0;

      // Reset after the word-2 response aborts the fill.
      @(negedge clk);
      start_miss(32'h0000_4440, 0, 0, acc, t0);
      n = 0;
      while (!(mem_req_valid && mem_req_address[3:2] == 2'd3) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) fail("word3_req_timeout");
      #2 rst = 1'b0;
      #1 chk_zero_outputs("midfill_reset");
      exp_fills.delete();
      exp_addrs.delete();
      m_way        = 0;
      m_last_valid = 0;
      miss_valid   = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // 17 distinct lines, first one restarts the aborted line.
      for (int i = 0; i < 17; i++) begin
         wait_idle();
         miss_valid = 1'b0;
         @(negedge clk);
         addr = (i == 0) ? 32'h0000_4448 : (32'h0002_0000 + 32'(i) * 32'h10);
         start_miss(addr, 1, 0, acc, t0);
      end
      wait_idle();
      miss_valid = 1'b0;

      // Randomised traffic over a small set of lines.
      rdy_random = 1;
      lat_max    = 3;
      stray_en   = 1;
      for (int it = 0; it < 60; it++) begin
         wait_idle();
         miss_valid = 1'b0;
         @(negedge clk);
         if ($urandom_range(3, 0) == 0) begin
            invalidate   = 1'b1;
            m_last_valid = 1'b0;
            @(negedge clk);
            invalidate = 1'b0;
         end
         addr = {28'h0000100 + 28'($urandom_range(5, 0)), 4'($urandom)};
         start_miss(addr, 0, 0, acc, t0);
         if (!acc) begin
            repeat (3) begin
               @(negedge clk);
               chk("rand_suppress", {159'd0, busy}, 160'd0);
            end
         end else if ($urandom_range(1, 0) == 1) begin
            @(negedge clk);
            if (busy) begin
               miss_address = addr ^ 32'h0100_0000;
               @(negedge clk);
               miss_address = addr;
            end
         end
      end
      wait_idle();
      miss_valid = 1'b0;
      stray_en   = 0;
      repeat (5) @(negedge clk);
      chk("fills_drained", 160'(exp_fills.size()), 160'd0);
      chk("reqs_drained",  160'(exp_addrs.size()), 160'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
